// File: rtl/gpio_keypad_pkg.sv
// rtl/gpio_keypad_pkg.sv - shared types and helpers for the keypad capture block
package gpio_keypad_pkg;

  localparam logic KEY_RELEASED = 1'b0;
  localparam logic KEY_PRESSED  = 1'b1;

  // Codes are stored at the widest supported size (32 keys) and trimmed at the port.
  localparam int KEY_CODE_W = 5;

  typedef struct packed {
    logic                  press;
    logic [KEY_CODE_W-1:0] code;
  } key_evt_t;

  function automatic int key_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce_ch.sv
// rtl/keypad_debounce_ch.sv - per-key synchroniser, debounce counter and stable level
module keypad_debounce_ch
  import gpio_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  input  logic enable_i,
  output logic chg_pulse_o,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // High in the cycle whose closing edge commits the new stable level.
  assign chg_pulse_o = enable_i && (s2_q != stable_q) && (cnt_q == CNT_LAST);
  assign level_o     = stable_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (!enable_i) begin
      stable_d = s2_q;
    end else if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = s2_q;
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= KEY_RELEASED;
      cnt_q    <= '0;
    end else begin
      s1_q     <= key_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_keypad_capture.sv
// rtl/gpio_keypad_capture.sv - keypad debounce, priority arbiter and press/release event FIFO
module gpio_keypad_capture
  import gpio_keypad_pkg::*;
#(
  parameter  int NUM_KEYS        = 4,
  parameter  int DEBOUNCE_CYCLES = 1_000_000,
  parameter  int FIFO_DEPTH      = 8,
  localparam int KW              = key_width(NUM_KEYS),
  localparam int AW              = $clog2(FIFO_DEPTH)
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                enable,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_code,
  output logic                evt_press,
  output logic [AW:0]         evt_count,
  output logic                irq,
  output logic                overflow,
  input  logic                clear_ovf
);

  logic [NUM_KEYS-1:0] chg, level;
  logic [NUM_KEYS-1:0] pend_q, pend_d, pdir_q, pdir_d;
  key_evt_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q, ovf_set;
  logic                found, pop, wr;
  logic [KW-1:0]       gidx;
  key_evt_t            head, wr_evt;
  logic                unused_code_hi;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    keypad_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk_i      (axi_aclk),
      .rst_ni     (axi_aresetn),
      .key_i      (key_in[k]),
      .enable_i   (enable),
      .chg_pulse_o(chg[k]),
      .level_o    (level[k])
    );
  end

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (pend_q[k] && !found) begin
        found = 1'b1;
        gidx  = KW'(k);
      end
    end
  end

  assign pop    = (count_q != '0) && evt_ready;
  assign wr     = found && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
  assign wr_evt = '{press: pdir_q[gidx], code: KEY_CODE_W'(gidx)};

  // A change landing on a still-pending key replaces its direction; the older edge is lost.
  always_comb begin
    pend_d  = pend_q;
    pdir_d  = pdir_q;
    ovf_set = 1'b0;
    if (wr) pend_d[gidx] = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (chg[k]) begin
        if (pend_d[k]) ovf_set = 1'b1;
        pend_d[k] = 1'b1;
        pdir_d[k] = (level[k] == KEY_PRESSED) ? KEY_RELEASED : KEY_PRESSED;
      end
    end
  end

  always_comb begin
    case ({wr, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pend_q   <= '0;
      pdir_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      count_q <= count_d;
      if (wr) begin
        mem_q[wr_ptr_q] <= wr_evt;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (ovf_set)        ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign evt_valid      = (count_q != '0);
  assign irq            = evt_valid;
  assign evt_count      = count_q;
  assign evt_code       = head.code[KW-1:0];
  assign evt_press      = head.press;
  assign overflow       = ovf_q;
  assign unused_code_hi = ^head.code;

endmodule

// File: tb/tb_gpio_keypad_capture.sv
// tb/tb_gpio_keypad_capture.sv - self-checking bench with a behavioural event model
module tb_gpio_keypad_capture;

  localparam int NK = 4;
  localparam int DB = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic          en, rdy, clr;
  logic          vld, prs, irq, ovf;
  logic [1:0]    code;
  logic [2:0]    cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_keypad_capture #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .key_in     (key),
    .enable     (en),
    .evt_valid  (vld),
    .evt_ready  (rdy),
    .evt_code   (code),
    .evt_press  (prs),
    .evt_count  (cnt),
    .irq        (irq),
    .overflow   (ovf),
    .clear_ovf  (clr)
  );

  typedef struct {bit press; int code;} ev_t;

  bit  m_s1[NK], m_s2[NK], m_stable[NK], m_pend[NK], m_pdir[NK];
  bit  m_hist[NK][$];
  bit  m_ovf;
  ev_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_stable[k] = 0; m_pend[k] = 0; m_pdir[k] = 0;
      m_hist[k].delete();
    end
    m_ovf = 0;
    mq.delete();
  endfunction

  // A key's level is accepted once its synchronised value has differed from the
  // accepted level on each of the last DB edges; events then queue in key order.
  function automatic void model_step();
    bit chg[NK];
    bit all_diff, pop, wr, set;
    int g;
    for (int k = 0; k < NK; k++) begin
      chg[k] = 0;
      m_hist[k].push_back(m_s2[k]);
      if (m_hist[k].size() > DB) void'(m_hist[k].pop_front());
      if (!en) m_stable[k] = m_s2[k];
      else begin
        all_diff = (m_hist[k].size() == DB);
        foreach (m_hist[k][i]) if (m_hist[k][i] == m_stable[k]) all_diff = 0;
        if (all_diff) begin
          chg[k] = 1;
          m_stable[k] = m_s2[k];
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = key[k];
    end
    pop = (mq.size() > 0) && rdy;
    g = -1;
    for (int k = 0; k < NK; k++) if (m_pend[k] && g < 0) g = k;
    wr = (g >= 0) && ((mq.size() < FD) || pop);
    if (pop) void'(mq.pop_front());
    if (wr) begin
      mq.push_back('{press: m_pdir[g], code: g});
      m_pend[g] = 0;
    end
    set = 0;
    for (int k = 0; k < NK; k++) begin
      if (chg[k]) begin
        if (m_pend[k]) set = 1;
        m_pend[k] = 1;
        m_pdir[k] = m_stable[k];
      end
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", vld, mq.size() > 0);
      chk("count", cnt, mq.size());
      chk("irq", irq, mq.size() > 0);
      chk("overflow", ovf, m_ovf);
      if (mq.size() > 0) begin
        chk("code", code, mq[0].code);
        chk("press", prs, mq[0].press);
      end
    end
  end

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    at_negedge();
    rdy = 1;
    @(posedge clk);
    #1;
    rdy = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, vld, 0);
    chk({name, "_count"}, cnt, 0);
    chk({name, "_irq"}, irq, 0);
    chk({name, "_ovf"}, ovf, 0);
    chk({name, "_code"}, code, 0);
    chk({name, "_press"}, prs, 0);
  endtask

  bit exp_dir[5] = '{1, 0, 1, 0, 0};
  int rmode;

  initial begin
    model_reset();
    rst_n = 0; key = '0; en = 1; rdy = 0; clr = 0;
    cycles(3);
    chk_all_zero("reset");
    at_negedge();
    rst_n = 1;
    cycles(4);

    // 1: press then release of key 0, evt_valid exactly at edge DB+3 = 19
    at_negedge(); key[0] = 1;
    cycles(18);
    chk("t1_valid_e18", vld, 0);
    cycles(1);
    chk("t1_valid_e19", vld, 1);
    chk("t1_code", code, 0);
    chk("t1_press", prs, 1);
    chk("t1_irq", irq, 1);
    pop_one();
    chk("t1_popped", vld, 0);
    cycles(20);
    at_negedge(); key[0] = 0;
    cycles(18);
    chk("t1r_valid_e18", vld, 0);
    cycles(1);
    chk("t1r_valid_e19", vld, 1);
    chk("t1r_press", prs, 0);
    pop_one();
    cycles(10);

    // 2: glitch shorter than the debounce window
    at_negedge(); key[2] = 1;
    cycles(10);
    at_negedge(); key[2] = 0;
    cycles(40);
    chk("t2_count", cnt, 0);

    // 3: simultaneous change on keys 1 and 3
    at_negedge(); key[1] = 1; key[3] = 1;
    cycles(19);
    chk("t3_count1", cnt, 1);
    chk("t3_head1", code, 1);
    cycles(1);
    chk("t3_count2", cnt, 2);
    pop_one();
    chk("t3_head3", code, 3);
    chk("t3_press3", prs, 1);
    pop_one();
    chk("t3_empty", vld, 0);
    cycles(10);

    // 4: FIFO full, pending hold, overflow and newest-direction replacement
    for (int i = 0; i < 5; i++) begin
      at_negedge(); key[0] = ~key[0];
      cycles(DB + 6);
    end
    chk("t4_full", cnt, 4);
    chk("t4_ovf0", ovf, 0);
    at_negedge(); key[0] = ~key[0];
    cycles(DB + 6);
    chk("t4_ovf1", ovf, 1);
    chk("t4_still_full", cnt, 4);
    at_negedge(); rdy = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_drain_valid", vld, 1);
      chk("t4_drain_code", code, 0);
      chk("t4_drain_press", prs, exp_dir[i]);
      @(posedge clk);
      #1;
    end
    chk("t4_drained", vld, 0);
    rdy = 0;
    at_negedge(); clr = 1;
    @(posedge clk); #1; clr = 0;
    chk("t4_clear", ovf, 0);

    // 5: enable low tracks silently, re-enable gives no spurious event
    at_negedge(); en = 0;
    for (int i = 0; i < 3; i++) begin
      at_negedge(); key[1] = ~key[1];
      cycles(DB + 4);
    end
    cycles(5);
    at_negedge(); en = 1;
    cycles(3 * DB);
    chk("t5_count", cnt, 0);

    // 6: reset mid-debounce with two events queued
    at_negedge(); key[0] = 1;
    cycles(DB + 6);
    at_negedge(); key[0] = 0;
    cycles(DB + 6);
    chk("t6_queued", cnt, 2);
    at_negedge(); key[2] = 1;
    cycles(8);
    at_negedge(); rst_n = 0;
    #1;
    chk_all_zero("t6_reset");
    cycles(3);
    at_negedge(); rst_n = 1;
    cycles(DB + 2);
    chk("t6_valid_early", vld, 0);
    cycles(1);
    chk("t6_valid", vld, 1);
    chk("t6_code", code, 2);
    chk("t6_press", prs, 1);
    pop_one();
    pop_one();
    cycles(5);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      at_negedge();
      if (c % 64 == 0) rmode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        int idx;
        idx = $urandom_range(0, NK - 1);
        key[idx] = ~key[idx];
      end
      rdy = (rmode == 1) || (rmode == 2 && $urandom_range(0, 1) == 1);
      if (en && $urandom_range(0, 399) == 0) en = 0;
      else if (!en && $urandom_range(0, 29) == 0) en = 1;
      clr = ($urandom_range(0, 49) == 0);
    end
    at_negedge();
    en = 1; clr = 0; rdy = 1;
    cycles(100);
    chk("final_empty", vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
